// File: rtl/raster_dispatch.sv
// raster_dispatch: takes triangle setup jobs from the setup stage through a
// one-entry hold register and hands each one to an idle rasterizer lane,
// round-robin. It signals frame completion once the last job is out and every
// lane has reported done.
// Optional build macro RASTER_DISPATCH_TIMEOUT_EN adds per-lane watchdogs and
// the sticky o_timeout output.
module raster_dispatch #(
  parameter int NUM_LANES      = 2,
  parameter int JOB_WIDTH      = 128,
  parameter int CNTWIDTH       = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_frame_start,
  input  logic                 i_job_valid,
  input  logic [JOB_WIDTH-1:0] i_job_data,
  input  logic                 i_job_last,
  output logic                 o_job_ready,
  output logic [NUM_LANES-1:0] o_lane_dv,
  output logic [JOB_WIDTH-1:0] o_lane_data,
  output logic                 o_lane_last,
  input  logic [NUM_LANES-1:0] i_lane_ready,
  input  logic [NUM_LANES-1:0] i_lane_done,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic [CNTWIDTH-1:0]  o_tri_count
`ifdef RASTER_DISPATCH_TIMEOUT_EN
  ,
  output logic [NUM_LANES-1:0] o_timeout
`endif
);

  localparam int PW = $clog2(NUM_LANES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic                   hold_full_q, hold_full_d;
  logic [JOB_WIDTH-1:0]   hold_data_q, hold_data_d;
  logic                   hold_last_q, hold_last_d;
  logic [NUM_LANES-1:0]   busy_q, busy_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [NUM_LANES-1:0]   lane_dv_q, lane_dv_d;
  logic [JOB_WIDTH-1:0]   lane_data_q, lane_data_d;
  logic                   lane_last_q, lane_last_d;
  logic [CNTWIDTH-1:0]    tri_count_q, tri_count_d;

  logic [NUM_LANES-1:0]   eligible;
  logic [NUM_LANES-1:0]   grant_vec;
  logic [PW-1:0]          grant_idx;
  logic [PW-1:0]          idx_l;
  logic                   grant_found;
  logic                   job_ready;
  logic                   dispatch;
  int                     idx;

`ifdef RASTER_DISPATCH_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0]      wdog_q [NUM_LANES];
  logic [WDOG_W-1:0]      wdog_d [NUM_LANES];
  logic [NUM_LANES-1:0]   timeout_q, timeout_d;
`endif

  // Round-robin arbiter: first eligible lane at or after the pointer, with wrap.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    eligible    = i_lane_ready & ~busy_q;
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_vec   = '0;
    idx         = 0;
    idx_l       = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_LANES) idx = idx - NUM_LANES;
      idx_l = PW'(idx);
      if (!grant_found && eligible[idx_l]) begin
        grant_found = 1'b1;
        grant_idx   = idx_l;
      end
    end
    if (grant_found) grant_vec[grant_idx] = 1'b1;
  end

  // Frame FSM, hold register, lane busy tracking and dispatch datapath.
  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    busy_d      = busy_q & ~i_lane_done;  // done on an idle lane is a no-op
    ptr_d       = ptr_q;
    lane_dv_d   = '0;                      // strobe lasts exactly one cycle
    lane_data_d = lane_data_q;
    lane_last_d = lane_last_q;
    tri_count_d = tri_count_q;
    job_ready   = 1'b0;
    dispatch    = 1'b0;
`ifdef RASTER_DISPATCH_TIMEOUT_EN
    timeout_d   = timeout_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_frame_start) begin
          state_d     = S_DISPATCH;
          tri_count_d = '0;
`ifdef RASTER_DISPATCH_TIMEOUT_EN
          timeout_d   = '0;
`endif
        end
      end
      S_DISPATCH: begin
        // Accept needs an empty hold and dispatch needs a full one, so the two
        // never touch the hold register in the same cycle.
        job_ready = !hold_full_q;
        if (i_job_valid && job_ready) begin
          hold_full_d = 1'b1;
          hold_data_d = i_job_data;
          hold_last_d = i_job_last;
        end
        if (hold_full_q && grant_found) begin
          dispatch    = 1'b1;
          lane_dv_d   = grant_vec;
          lane_data_d = hold_data_q;
          lane_last_d = hold_last_q;
          busy_d      = busy_d | grant_vec;
          hold_full_d = 1'b0;
          ptr_d       = (int'(grant_idx) == NUM_LANES - 1) ? '0 : grant_idx + PW'(1);
          tri_count_d = (tri_count_q == '1) ? tri_count_q : tri_count_q + CNTWIDTH'(1);
          if (hold_last_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (busy_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef RASTER_DISPATCH_TIMEOUT_EN
    // Watchdog: count busy cycles per lane and force the lane free at the limit.
    for (int k = 0; k < NUM_LANES; k++) begin
      wdog_d[k] = wdog_q[k];
      if (dispatch && grant_vec[k]) begin
        wdog_d[k] = '0;
      end else if (busy_q[k]) begin
        if (wdog_q[k] == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
          busy_d[k]    = 1'b0;
          timeout_d[k] = 1'b1;
          wdog_d[k]    = '0;
        end else begin
          wdog_d[k] = wdog_q[k] + WDOG_W'(1);
        end
      end
    end
`endif
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q     <= S_IDLE;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
      busy_q      <= '0;
      ptr_q       <= '0;
      lane_dv_q   <= '0;
      lane_data_q <= '0;
      lane_last_q <= 1'b0;
      tri_count_q <= '0;
`ifdef RASTER_DISPATCH_TIMEOUT_EN
      timeout_q   <= '0;
      // NOTE: the watchdog array is a handful of flops, not a RAM, so it is reset like any other state.
      for (int k = 0; k < NUM_LANES; k++) wdog_q[k] <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
      lane_dv_q   <= lane_dv_d;
      lane_data_q <= lane_data_d;
      lane_last_q <= lane_last_d;
      tri_count_q <= tri_count_d;
`ifdef RASTER_DISPATCH_TIMEOUT_EN
      timeout_q   <= timeout_d;
      for (int k = 0; k < NUM_LANES; k++) wdog_q[k] <= wdog_d[k];
`endif
    end
  end

  assign o_job_ready  = job_ready;
  assign o_lane_dv    = lane_dv_q;
  assign o_lane_data  = lane_data_q;
  assign o_lane_last  = lane_last_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_frame_done = (state_q == S_DONE);
  assign o_tri_count  = tri_count_q;
`ifdef RASTER_DISPATCH_TIMEOUT_EN
  assign o_timeout    = timeout_q;
`endif

endmodule

// File: tb/tb_raster_dispatch.sv
// Self-checking bench for raster_dispatch: behavioural lane models, a job
// scoreboard and a round-robin reference driven by randomized stimulus.
// Build with RASTER_DISPATCH_TIMEOUT_EN to also exercise the lane watchdog.
module tb_raster_dispatch;

  localparam int NL = 2;
  localparam int JW = 128;
  localparam int CW = 16;
  localparam int TO = 20;

  typedef struct packed {
    logic [JW-1:0] data;
    logic          last;
  } job_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_frame_start;
  logic          i_job_valid;
  logic [JW-1:0] i_job_data;
  logic          i_job_last;
  logic          o_job_ready;
  logic [NL-1:0] o_lane_dv;
  logic [JW-1:0] o_lane_data;
  logic          o_lane_last;
  logic [NL-1:0] i_lane_ready;
  logic [NL-1:0] i_lane_done;
  logic          o_busy;
  logic          o_frame_done;
  logic [CW-1:0] o_tri_count;
`ifdef RASTER_DISPATCH_TIMEOUT_EN
  logic [NL-1:0] o_timeout;
`endif

  raster_dispatch #(
    .NUM_LANES(NL), .JOB_WIDTH(JW), .CNTWIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .i_frame_start(i_frame_start),
    .i_job_valid(i_job_valid), .i_job_data(i_job_data), .i_job_last(i_job_last),
    .o_job_ready(o_job_ready), .o_lane_dv(o_lane_dv), .o_lane_data(o_lane_data),
    .o_lane_last(o_lane_last), .i_lane_ready(i_lane_ready), .i_lane_done(i_lane_done),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_tri_count(o_tri_count)
`ifdef RASTER_DISPATCH_TIMEOUT_EN
    , .o_timeout(o_timeout)
`endif
  );

  always #5 clk = ~clk;

  // Counters and reference-model state.
  int checks = 0;
  int errors = 0;
  int tick_no = 0;
  job_t send_q[$];
  job_t exp_q[$];
  int   lane_log[$];
  int   rem[NL];
  bit   stuck[NL];
  bit   ready_en[NL];
  bit   just_disp[NL];
  int   to_tick[NL];
  int   lat_min = 1, lat_max = 4, valid_pct = 100;
  bit   spur_done = 1'b0;
  logic [NL-1:0] mb = '0;         // lanes the reference considers busy this cycle
  logic [NL-1:0] elig_prev = '0;  // eligibility presented at the coming edge
  int   ptr_m = 0, cnt_m = 0;
  int   frame_done_cnt = 0, fd_tick = 0, last_done_tick = 0;
  bit   fs_req = 0, fs_prev = 0, fs_idle_prev = 0;
  bit   ready_low_watch = 0;
  logic [NL-1:0] to_exp = '0;

  // One clock of the bench: observe at the falling edge, update models, drive inputs.
  task automatic tick();
    logic [NL-1:0] dv, done, ready, ev;
    int exp_lane, k;
    job_t j;
    @(negedge clk);
    tick_no++;
    dv = o_lane_dv;
    if (fs_prev && fs_idle_prev) begin
      cnt_m  = 0;
      to_exp = '0;
    end
    if (dv != '0) begin
      exp_lane = -1;
      for (int i = 0; i < NL; i++) begin
        int c;
        c = (ptr_m + i) % NL;
        if (exp_lane < 0 && elig_prev[c]) exp_lane = c;
      end
      ev = '0;
      if (exp_lane >= 0) ev[exp_lane] = 1'b1;
      checks++;
      if (exp_lane < 0 || dv !== ev) begin
        errors++;
        $display("FAIL dispatch_lane: o_lane_dv=%b expected=%b (eligible %b ptr %0d) t=%0d",
                 dv, ev, elig_prev, ptr_m, tick_no);
      end
      k = 0;
      for (int i = NL - 1; i >= 0; i--) if (dv[i]) k = i;
      lane_log.push_back(k);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dispatch_unexpected: o_lane_dv=%b with no accepted job pending t=%0d", dv, tick_no);
      end else begin
        j = exp_q.pop_front();
        if ({o_lane_data, o_lane_last} !== j) begin
          errors++;
          $display("FAIL lane_payload: data=%h last=%b expected data=%h last=%b",
                   o_lane_data, o_lane_last, j.data, j.last);
        end
      end
      for (int i = 0; i < NL; i++) if (dv[i]) begin
        rem[i] = $urandom_range(lat_min, lat_max);
        mb[i]  = 1'b1;
        if (stuck[i]) to_tick[i] = tick_no + TO;
      end
      ptr_m = (k + 1) % NL;
      cnt_m++;
    end
    checks++;
    if (o_tri_count !== CW'(cnt_m)) begin
      errors++;
      $display("FAIL tri_count: o_tri_count=%0d expected=%0d t=%0d", o_tri_count, cnt_m, tick_no);
    end
    if (o_frame_done === 1'b1) begin
      frame_done_cnt++;
      fd_tick = tick_no;
    end
    if (ready_low_watch) begin
      checks++;
      if (o_job_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_low: o_job_ready=%b expected 0 t=%0d", o_job_ready, tick_no);
      end
    end
`ifdef RASTER_DISPATCH_TIMEOUT_EN
    for (int i = 0; i < NL; i++) if (to_tick[i] == tick_no) begin
      to_exp[i] = 1'b1;
      mb[i]     = 1'b0;
    end
    checks++;
    if (o_timeout !== to_exp) begin
      errors++;
      $display("FAIL timeout_flags: o_timeout=%b expected=%b t=%0d", o_timeout, to_exp, tick_no);
    end
`endif
    // Lane models: work for rem cycles after dv, pulse done, stay ready one cycle past dv.
    for (int i = 0; i < NL; i++) begin
      done[i] = 1'b0;
      if (dv[i]) begin
        just_disp[i] = 1'b1;
      end else begin
        just_disp[i] = 1'b0;
        if (rem[i] > 0 && !stuck[i]) begin
          rem[i]--;
          if (rem[i] == 0) begin
            done[i] = 1'b1;
            last_done_tick = tick_no;
          end
        end else if (rem[i] == 0 && !mb[i] && spur_done && $urandom_range(0, 7) == 0) begin
          done[i] = 1'b1;
        end
      end
      ready[i] = ready_en[i] && (rem[i] == 0 || just_disp[i]);
    end
    i_lane_done  = done;
    i_lane_ready = ready;
    elig_prev    = ready & ~mb;
    mb           = mb & ~done;
    // Upstream job source.
    if (send_q.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
      i_job_valid = 1'b1;
      i_job_data  = send_q[0].data;
      i_job_last  = send_q[0].last;
      if (o_job_ready === 1'b1) exp_q.push_back(send_q.pop_front());
    end else begin
      i_job_valid = 1'b0;
      i_job_data  = {$urandom, $urandom, $urandom, $urandom};
      i_job_last  = 1'(($urandom_range(0, 1)));
    end
    fs_idle_prev  = !o_busy;
    fs_prev       = fs_req;
    i_frame_start = fs_req;
    fs_req        = 1'b0;
  endtask

  task automatic queue_jobs(input int n);
    job_t j;
    for (int i = 0; i < n; i++) begin
      j.data = {$urandom, $urandom, $urandom, $urandom};
      j.last = (i == n - 1);
      send_q.push_back(j);
    end
  endtask

  task automatic wait_frame(input int budget, input string name);
    int start, n;
    start = frame_done_cnt;
    n = 0;
    while (frame_done_cnt == start && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (frame_done_cnt == start) begin
      errors++;
      $display("FAIL %s_frame_done: no o_frame_done within %0d cycles", name, budget);
    end
    repeat (4) tick();
    checks++;
    if (frame_done_cnt != start + 1) begin
      errors++;
      $display("FAIL %s_done_pulses: saw %0d o_frame_done cycles, expected 1", name, frame_done_cnt - start);
    end
    checks++;
    if (exp_q.size() != 0 || send_q.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover: %0d accepted and %0d unsent jobs remain, expected 0",
               name, exp_q.size(), send_q.size());
    end
  endtask

  task automatic apply_reset(input int cycles);
    rstn = 1'b0;
    fs_req = 1'b0;
    send_q.delete();
    exp_q.delete();
    mb = '0;
    elig_prev = '0;
    ptr_m = 0;
    cnt_m = 0;
    to_exp = '0;
    for (int i = 0; i < NL; i++) to_tick[i] = -1;
    repeat (cycles) tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (o_job_ready !== 1'b0 || o_lane_dv !== '0 || o_lane_last !== 1'b0 || o_busy !== 1'b0 ||
        o_frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_ctrl: ready=%b dv=%b last=%b busy=%b done=%b expected all 0",
               name, o_job_ready, o_lane_dv, o_lane_last, o_busy, o_frame_done);
    end
    checks++;
    if (o_lane_data !== '0 || o_tri_count !== '0) begin
      errors++;
      $display("FAIL %s_data: lane_data=%h tri_count=%0d expected 0", name, o_lane_data, o_tri_count);
    end
  endtask

  task automatic test_reset();
    apply_reset(3);
    check_idle_outputs("reset");
  endtask

  task automatic test_basic();
    int exp_order[4] = '{0, 1, 0, 1};
    lat_min = 5; lat_max = 5; valid_pct = 100;
    lane_log.delete();
    queue_jobs(4);
    fs_req = 1'b1;
    wait_frame(200, "basic");
    checks++;
    if (lane_log.size() != 4) begin
      errors++;
      $display("FAIL basic_count: %0d dispatches, expected 4", lane_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (lane_log[i] != exp_order[i]) begin
          errors++;
          $display("FAIL basic_order: dispatch %0d went to lane %0d, expected lane %0d", i, lane_log[i], exp_order[i]);
        end
      end
    end
    checks++;
    if (o_tri_count !== CW'(4)) begin
      errors++;
      $display("FAIL basic_tri_count: o_tri_count=%0d expected 4", o_tri_count);
    end
  endtask

  task automatic test_lane0_blocked();
    lat_min = 5; lat_max = 5;
    ready_en[0] = 1'b0;
    lane_log.delete();
    queue_jobs(3);
    fs_req = 1'b1;
    wait_frame(200, "blocked");
    checks++;
    if (lane_log.size() != 3 || lane_log[0] != 1 || lane_log[1] != 1 || lane_log[2] != 1) begin
      errors++;
      $display("FAIL blocked_lanes: %0d dispatches, first lanes %p, expected 3 to lane 1", lane_log.size(), lane_log);
    end
    checks++;
    if (o_tri_count !== CW'(3)) begin
      errors++;
      $display("FAIL blocked_tri_count: o_tri_count=%0d expected 3", o_tri_count);
    end
    ready_en[0] = 1'b1;
  endtask

  task automatic test_single();
    int n;
    lat_min = 6; lat_max = 6;
    queue_jobs(1);
    fs_req = 1'b1;
    n = 0;
    while (send_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    ready_low_watch = 1'b1;
    wait_frame(100, "single");
    repeat (3) tick();
    ready_low_watch = 1'b0;
    checks++;
    if (fd_tick != last_done_tick + 2) begin
      errors++;
      $display("FAIL single_done_latency: frame_done at t=%0d, lane done driven t=%0d, expected t=%0d",
               fd_tick, last_done_tick, last_done_tick + 2);
    end
    checks++;
    if (o_tri_count !== CW'(1)) begin
      errors++;
      $display("FAIL single_tri_count: o_tri_count=%0d expected 1", o_tri_count);
    end
  endtask

  task automatic test_idle_valid();
    int base, n;
    lat_min = 10; lat_max = 10; valid_pct = 100;
    lane_log.delete();
    queue_jobs(3);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (o_job_ready !== 1'b0 || send_q.size() != 3) begin
        errors++;
        $display("FAIL idle_no_accept: o_job_ready=%b unsent=%0d expected 0 and 3", o_job_ready, send_q.size());
      end
    end
    base = lane_log.size();
    fs_req = 1'b1;
    n = 0;
    while (lane_log.size() < base + 2 && n < 100) begin
      tick();
      n++;
    end
    fs_req = 1'b1;
    repeat (3) tick();
    checks++;
    if (o_busy !== 1'b1 || o_tri_count !== CW'(2)) begin
      errors++;
      $display("FAIL spurious_start: busy=%b tri_count=%0d expected 1 and 2", o_busy, o_tri_count);
    end
    wait_frame(200, "spurious");
    checks++;
    if (o_tri_count !== CW'(3)) begin
      errors++;
      $display("FAIL spurious_tri_count: o_tri_count=%0d expected 3", o_tri_count);
    end
  endtask

  task automatic test_random();
    int n;
    lat_min = 1; lat_max = 8; valid_pct = 60;
    spur_done = 1'b1;
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < NL; i++) ready_en[i] = ($urandom_range(0, 3) != 0);
      if (!ready_en[0] && !ready_en[1]) ready_en[0] = 1'b1;
      queue_jobs(n);
      fs_req = 1'b1;
      wait_frame(600, "random");
      checks++;
      if (o_tri_count !== CW'(n)) begin
        errors++;
        $display("FAIL random_tri_count: o_tri_count=%0d expected %0d (frame %0d)", o_tri_count, n, f);
      end
    end
    spur_done = 1'b0;
    for (int i = 0; i < NL; i++) ready_en[i] = 1'b1;
    valid_pct = 100;
  endtask

  task automatic test_reset_mid_drain();
    int base, n;
    lat_min = 40; lat_max = 40;
    queue_jobs(1);
    fs_req = 1'b1;
    base = lane_log.size();
    n = 0;
    while (lane_log.size() == base && n < 50) begin
      tick();
      n++;
    end
    repeat (2) tick();
    checks++;
    if (o_busy !== 1'b1 || o_job_ready !== 1'b0) begin
      errors++;
      $display("FAIL drain_state: busy=%b ready=%b expected 1 and 0 before reset", o_busy, o_job_ready);
    end
    apply_reset(3);
    check_idle_outputs("reset_drain");
    base = lane_log.size();
    repeat (20) tick();
    checks++;
    if (lane_log.size() != base || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_drain_quiet: %0d dispatches and busy=%b after reset, expected 0 and 0",
               lane_log.size() - base, o_busy);
    end
    n = 0;
    while ((rem[0] != 0 || rem[1] != 0) && n < 100) begin
      tick();
      n++;
    end
  endtask

`ifdef RASTER_DISPATCH_TIMEOUT_EN
  task automatic test_timeout();
    lat_min = 4; lat_max = 4;
    stuck[1] = 1'b1;
    queue_jobs(3);
    fs_req = 1'b1;
    wait_frame(300, "timeout");
    checks++;
    if (o_timeout !== 2'b10) begin
      errors++;
      $display("FAIL timeout_sticky: o_timeout=%b expected 10", o_timeout);
    end
    stuck[1] = 1'b0;
    rem[1] = 0;
    queue_jobs(1);
    fs_req = 1'b1;
    wait_frame(100, "timeout_clear");
    checks++;
    if (o_timeout !== 2'b00) begin
      errors++;
      $display("FAIL timeout_clear: o_timeout=%b expected 00", o_timeout);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation did not finish in time");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    i_frame_start = 1'b0;
    i_job_valid = 1'b0;
    i_job_data = '0;
    i_job_last = 1'b0;
    i_lane_ready = '0;
    i_lane_done = '0;
    for (int i = 0; i < NL; i++) begin
      rem[i] = 0;
      stuck[i] = 1'b0;
      ready_en[i] = 1'b1;
      just_disp[i] = 1'b0;
      to_tick[i] = -1;
    end
    test_reset();
    test_basic();
    test_lane0_blocked();
    test_single();
    test_idle_valid();
    test_random();
    test_reset_mid_drain();
`ifdef RASTER_DISPATCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
